// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum display path.
//   NUM_BANDS  : number of bars the VGA controller draws
//   HEIGHT_W   : width of one bar height / peak value
//   BAND_IDX_W : width of a band index
// Also provides the FSM state encoding for the height engine and the helper
// that turns a raw band magnitude into a clamped height.
package spectrum_pkg;

  localparam int NUM_BANDS  = 20;
  localparam int HEIGHT_W   = 6;
  localparam int BAND_IDX_W = 5;

  typedef logic [HEIGHT_W-1:0]   height_t;
  typedef logic [BAND_IDX_W-1:0] band_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_PUBLISH
  } engine_state_t;

  // Scale a 16-bit magnitude down by 'shift' and clamp it to 'max_h'.
  function automatic height_t mag_to_height(input logic [15:0] mag,
                                            input int          shift,
                                            input int          max_h);
    logic [15:0] raw;
    raw = mag >> shift;
    if (raw > 16'(max_h)) return height_t'(max_h);
    return height_t'(raw);
  endfunction

endpackage

// File: rtl/bar_dynamics.sv
// Combinational per-band dynamics: instant attack, linear decay, peak hold.
// Ports:
//   snap      : height sampled from the band target at the start of the frame
//   cur       : currently displayed height
//   peak      : current peak marker
//   hold      : frames left before the peak starts falling
//   cur_next  : new displayed height
//   peak_next : new peak marker
//   hold_next : new hold count
module bar_dynamics
  import spectrum_pkg::*;
#(
  parameter int DECAY_STEP  = 2,
  parameter int HOLD_FRAMES = 8,
  parameter int HOLD_W      = $clog2(HOLD_FRAMES + 1)
) (
  input  height_t           snap,
  input  height_t           cur,
  input  height_t           peak,
  input  logic [HOLD_W-1:0] hold,
  output height_t           cur_next,
  output height_t           peak_next,
  output logic [HOLD_W-1:0] hold_next
);

  height_t cur_dec;
  height_t peak_dec;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cur_dec   = '0;
    peak_dec  = '0;
    cur_next  = snap;
    peak_next = peak;
    hold_next = hold;

    // Decay saturates at zero instead of wrapping.
    if (cur > height_t'(DECAY_STEP)) cur_dec = cur - height_t'(DECAY_STEP);

    if (snap >= cur) cur_next = snap;
    else             cur_next = (cur_dec > snap) ? cur_dec : snap;

    if (cur_next >= peak) begin
      peak_next = cur_next;
      hold_next = HOLD_W'(HOLD_FRAMES);
    end else if (hold != '0) begin
      hold_next = hold - 1'b1;
    end else begin
      // Here peak > cur_next >= 0, so peak - 1 cannot underflow.
      peak_dec  = peak - 1'b1;
      peak_next = (peak_dec > cur_next) ? peak_dec : cur_next;
    end
  end

endmodule

// File: rtl/bar_height_engine.sv
// Bar height engine: collects band magnitudes as they arrive, and once per
// frame walks all bands through one shared dynamics unit, then publishes a
// complete, tear-free height/peak set for the VGA controller.
// Ports:
//   CLK, RESET_N   : clock, asynchronous active-low reset
//   BAND_VALID     : write strobe for one band magnitude
//   BAND_INDEX     : band number 0..19 (20..31 ignored)
//   BAND_MAG       : unsigned band magnitude
//   FRAME_TICK     : one-cycle pulse at start of vertical blank
//   HEIGHTS, PEAKS : band b at [6b+5:6b]
//   UPDATE_DONE    : one-cycle pulse in the cycle HEIGHTS/PEAKS change
//   BUSY           : frame walk in progress
//   FRAME_MISSED   : one-cycle pulse, FRAME_TICK arrived while BUSY
module bar_height_engine
  import spectrum_pkg::*;
#(
  parameter int MAG_SHIFT   = 10,
  parameter int MAX_HEIGHT  = 48,
  parameter int DECAY_STEP  = 2,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          BAND_VALID,
  input  logic [BAND_IDX_W-1:0]         BAND_INDEX,
  input  logic [15:0]                   BAND_MAG,
  input  logic                          FRAME_TICK,
  output logic [NUM_BANDS*HEIGHT_W-1:0] HEIGHTS,
  output logic [NUM_BANDS*HEIGHT_W-1:0] PEAKS,
  output logic                          UPDATE_DONE,
  output logic                          BUSY,
  output logic                          FRAME_MISSED
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  engine_state_t state_q, state_d;
  band_idx_t     walk_idx;
  logic          start_walk;
  logic          publish;
  logic          write_ok;

  height_t           target   [NUM_BANDS];
  height_t           snapshot [NUM_BANDS];
  height_t           current  [NUM_BANDS];
  height_t           peak     [NUM_BANDS];
  height_t           shadow_h [NUM_BANDS];
  height_t           shadow_p [NUM_BANDS];
  logic [HOLD_W-1:0] hold     [NUM_BANDS];

  height_t           cur_next, peak_next;
  logic [HOLD_W-1:0] hold_next;

  assign write_ok = BAND_VALID && (BAND_INDEX < band_idx_t'(NUM_BANDS));
  assign BUSY     = (state_q != ST_IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_walk = 1'b0;
    publish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FRAME_TICK) begin
          start_walk = 1'b1;
          state_d    = ST_WALK;
        end
      end
      ST_WALK: begin
        if (walk_idx == band_idx_t'(NUM_BANDS - 1)) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        publish = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                walk_idx <= '0;
    else if (start_walk)         walk_idx <= '0;
    else if (state_q == ST_WALK) walk_idx <= walk_idx + 1'b1;
  end

  // ------------------------------------------------ targets and snapshot
  // NOTE: these arrays are plain flops, not RAM, and reset must leave every
  // band at zero, so each entry is cleared explicitly in the reset branch.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        target[b]   <= '0;
        snapshot[b] <= '0;
      end
    end else begin
      if (start_walk) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          snapshot[b] <= target[b];
          target[b]   <= '0;
        end
      end
      // NOTE: the last non-blocking assignment to an element wins, so a write
      // in the tick cycle overrides the clear while the snapshot still sees
      // the old target value.
      if (write_ok)
        target[BAND_INDEX] <= mag_to_height(BAND_MAG, MAG_SHIFT, MAX_HEIGHT);
    end
  end

  // ------------------------------------------------ shared dynamics unit
  bar_dynamics #(
    .DECAY_STEP  (DECAY_STEP),
    .HOLD_FRAMES (HOLD_FRAMES),
    .HOLD_W      (HOLD_W)
  ) u_dynamics (
    .snap      (snapshot[walk_idx]),
    .cur       (current[walk_idx]),
    .peak      (peak[walk_idx]),
    .hold      (hold[walk_idx]),
    .cur_next  (cur_next),
    .peak_next (peak_next),
    .hold_next (hold_next)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        current[b]  <= '0;
        peak[b]     <= '0;
        hold[b]     <= '0;
        shadow_h[b] <= '0;
        shadow_p[b] <= '0;
      end
    end else if (state_q == ST_WALK) begin
      current[walk_idx]  <= cur_next;
      peak[walk_idx]     <= peak_next;
      hold[walk_idx]     <= hold_next;
      shadow_h[walk_idx] <= cur_next;
      shadow_p[walk_idx] <= peak_next;
    end
  end

  // ------------------------------------------------ published outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      HEIGHTS      <= '0;
      PEAKS        <= '0;
      UPDATE_DONE  <= 1'b0;
      FRAME_MISSED <= 1'b0;
    end else begin
      UPDATE_DONE  <= publish;
      FRAME_MISSED <= FRAME_TICK && BUSY;
      if (publish) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          HEIGHTS[b*HEIGHT_W +: HEIGHT_W] <= shadow_h[b];
          PEAKS[b*HEIGHT_W +: HEIGHT_W]   <= shadow_p[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_bar_height_engine.sv
// Self-checking bench for bar_height_engine: directed frame sequences plus
// randomized writes and ticks compared every cycle against a frame-level
// reference model.
module tb_bar_height_engine;

  localparam int NB = 20;

  logic         CLK;
  logic         RESET_N;
  logic         BAND_VALID;
  logic [4:0]   BAND_INDEX;
  logic [15:0]  BAND_MAG;
  logic         FRAME_TICK;
  logic [119:0] HEIGHTS;
  logic [119:0] PEAKS;
  logic         UPDATE_DONE;
  logic         BUSY;
  logic         FRAME_MISSED;

  bar_height_engine dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .BAND_VALID   (BAND_VALID),
    .BAND_INDEX   (BAND_INDEX),
    .BAND_MAG     (BAND_MAG),
    .FRAME_TICK   (FRAME_TICK),
    .HEIGHTS      (HEIGHTS),
    .PEAKS        (PEAKS),
    .UPDATE_DONE  (UPDATE_DONE),
    .BUSY         (BUSY),
    .FRAME_MISSED (FRAME_MISSED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [119:0] act, input logic [119:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------- reference model
  // Tracks targets as written, and applies a whole frame of dynamics at the
  // moment the published set is due (21 clocks after an accepted tick).
  int m_target [NB];
  int m_snap   [NB];
  int m_cur    [NB];
  int m_peak   [NB];
  int m_hold   [NB];
  int m_out_h  [NB];
  int m_out_p  [NB];
  int m_rem;
  bit m_done;
  bit m_missed;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [119:0] pack(input int a [NB]);
    logic [119:0] v;
    v = '0;
    for (int b = 0; b < NB; b++) v[b*6 +: 6] = 6'(a[b]);
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_target[b] = 0; m_snap[b] = 0; m_cur[b] = 0; m_peak[b] = 0;
      m_hold[b] = 0; m_out_h[b] = 0; m_out_p[b] = 0;
    end
    m_rem = 0; m_done = 0; m_missed = 0;
  endtask

  task automatic model_frame();
    for (int b = 0; b < NB; b++) begin
      if (m_snap[b] >= m_cur[b]) m_cur[b] = m_snap[b];
      else                       m_cur[b] = imax(m_cur[b] - 2, m_snap[b]);
      if (m_cur[b] >= m_peak[b]) begin
        m_peak[b] = m_cur[b];
        m_hold[b] = 8;
      end else if (m_hold[b] > 0) begin
        m_hold[b]--;
      end else begin
        m_peak[b] = imax(m_peak[b] - 1, m_cur[b]);
      end
      m_out_h[b] = m_cur[b];
      m_out_p[b] = m_peak[b];
    end
  endtask

  task automatic model_edge(input bit v, input int idx, input int mag, input bit tick);
    int r_before;
    r_before = m_rem;
    m_done   = 0;
    m_missed = 0;
    if (r_before > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        model_frame();
        m_done = 1;
      end
    end
    if (tick) begin
      if (r_before == 0) begin
        for (int b = 0; b < NB; b++) begin
          m_snap[b]   = m_target[b];
          m_target[b] = 0;
        end
        m_rem = 21;
      end else begin
        m_missed = 1;
      end
    end
    if (v && idx < NB) m_target[idx] = (mag >> 10 > 48) ? 48 : (mag >> 10);
  endtask

  task automatic check_all();
    check("heights", HEIGHTS, pack(m_out_h));
    check("peaks", PEAKS, pack(m_out_p));
    check("busy", 120'(BUSY), 120'(m_rem > 0));
    check("update_done", 120'(UPDATE_DONE), 120'(m_done));
    check("frame_missed", 120'(FRAME_MISSED), 120'(m_missed));
  endtask

  // One clock: drive inputs at the falling edge, step the model at the
  // rising edge, compare at the next falling edge.
  task automatic cyc(input bit v, input int idx, input int mag, input bit tick);
    BAND_VALID = v;
    BAND_INDEX = idx[4:0];
    BAND_MAG   = mag[15:0];
    FRAME_TICK = tick;
    @(posedge CLK);
    model_edge(v, idx, mag, tick);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Tick, then run a bounded window recording when UPDATE_DONE shows up and
  // how many sampled cycles BUSY was high.
  task automatic frame(output int done_at, output int busy_cycles);
    done_at     = -1;
    busy_cycles = 0;
    cyc(0, 0, 0, 1);
    if (BUSY) busy_cycles++;
    for (int i = 1; i <= 25; i++) begin
      cyc(0, 0, 0, 0);
      if (BUSY) busy_cycles++;
      if (UPDATE_DONE && done_at < 0) done_at = i;
    end
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    @(negedge CLK);
    check_all();
    RESET_N = 1'b1;
  endtask

  function automatic int band(input logic [119:0] v, input int b);
    return int'(v[b*6 +: 6]);
  endfunction

  int d, bc, eh, ep, dones;
  logic [119:0] ev;

  initial begin
    RESET_N    = 1'b0;
    BAND_VALID = 1'b0;
    BAND_INDEX = '0;
    BAND_MAG   = '0;
    FRAME_TICK = 1'b0;
    model_reset();
    @(negedge CLK);
    apply_reset();

    // Idle after reset: nothing changes.
    idle(100);
    check("idle_heights", HEIGHTS, '0);

    // Single band, first frame.
    cyc(1, 3, 'h6000, 0);
    frame(d, bc);
    check("latency", 120'(d), 120'(21));
    check("busy_len", 120'(bc), 120'(21));
    ev = '0; ev[23:18] = 6'd24;
    check("f1_heights", HEIGHTS, ev);
    check("f1_peaks", PEAKS, ev);

    // Decay and peak hold with no new writes.
    for (int f = 2; f <= 13; f++) begin
      frame(d, bc);
      eh = 24 - 2 * (f - 1);
      ep = (f <= 9) ? 24 : imax(24 - (f - 9), eh);
      check($sformatf("b3_h_f%0d", f), 120'(band(HEIGHTS, 3)), 120'(eh));
      check($sformatf("b3_p_f%0d", f), 120'(band(PEAKS, 3)), 120'(ep));
    end

    // Clamp on band 19; index 20 is ignored.
    cyc(1, 19, 'hFFFF, 0);
    cyc(1, 20, 'hFFFF, 0);
    frame(d, bc);
    check("b19_clamp", 120'(band(HEIGHTS, 19)), 120'(48));
    check("b19_peak", 120'(band(PEAKS, 19)), 120'(48));

    // Second tick mid-walk is reported and otherwise ignored; a write
    // during the walk only shows up a frame later.
    cyc(1, 7, 'h3000, 0);
    cyc(0, 0, 0, 1);
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 5)       cyc(1, 5, 'h8000, 0);
      else if (i == 10) cyc(0, 0, 0, 1);
      else              cyc(0, 0, 0, 0);
      if (i == 10) check("missed_pulse", 120'(FRAME_MISSED), 120'(1));
      if (UPDATE_DONE) begin
        dones++;
        check("double_tick_latency", 120'(i), 120'(21));
      end
    end
    check("single_done", 120'(dones), 120'(1));
    check("b7_after", 120'(band(HEIGHTS, 7)), 120'(12));
    check("b5_this_frame", 120'(band(HEIGHTS, 5)), 120'(0));
    frame(d, bc);
    check("b5_next_frame", 120'(band(HEIGHTS, 5)), 120'(32));

    // Reset in the middle of a walk.
    cyc(0, 0, 0, 1);
    idle(9);
    apply_reset();
    check("rst_heights", HEIGHTS, '0);
    check("rst_peaks", PEAKS, '0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 0);
      if (UPDATE_DONE) dones++;
    end
    check("no_done_after_rst", 120'(dones), 120'(0));
    cyc(1, 3, 'h6000, 0);
    frame(d, bc);
    check("post_rst_latency", 120'(d), 120'(21));
    ev = '0; ev[23:18] = 6'd24;
    check("post_rst_heights", HEIGHTS, ev);
    check("post_rst_peaks", PEAKS, ev);

    // Randomized writes and ticks, model compared every cycle.
    for (int i = 0; i < 4000; i++) begin
      bit v, t;
      int idx, mag;
      v   = ($urandom_range(0, 2) == 0);
      idx = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       mag = $urandom_range(0, 'h3FF);
        1:       mag = $urandom_range(0, 'h7FFF);
        default: mag = $urandom_range(0, 'hFFFF);
      endcase
      t = ($urandom_range(0, 24) == 0);
      cyc(v, idx, mag, t);
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
